// File: rtl/mux_arbiter_0.sv
// Round-robin arbiter driving a mux_0 tree; registered one-hot grant held until the owner releases.
// Optional per-ownership timeout is compiled in with MUX_ARB_TIMEOUT_EN.

module mux_0 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);
  assign y = (a & ~s) | (b & s);
endmodule

module and_0 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module mux_arbiter_0 #(
  parameter int NUM_REQ  = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         data_in,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] sel,
  output logic                       busy,
  output logic                       out
);
  localparam int SEL_W = $clog2(NUM_REQ);

  if (!(NUM_REQ == 2 || NUM_REQ == 4 || NUM_REQ == 8) || HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_params
    $error("mux_arbiter_0: illegal NUM_REQ or HOLD_MAX");
  end

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   ptr_reg, ptr_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic               busy_reg, busy_next;

  logic [SEL_W-1:0]   win;
  logic [SEL_W-1:0]   idx;
  logic               found;
  logic               timeout;
  logic               owner_done;

  // Scan offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    win   = ptr_reg;
    idx   = ptr_reg;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr_reg + SEL_W'(i);
      if (req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign owner_done = ~req[sel_reg] | timeout;

`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] hold_reg, hold_next;

  assign timeout = (hold_reg == 8'(HOLD_MAX - 1));

  always_comb begin
    hold_next = hold_reg;
    case (state_reg)
      IDLE:    if (found) hold_next = 8'd0;
      OWN:     hold_next = owner_done ? 8'd0 : hold_reg + 8'd1;
      default: hold_next = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) hold_reg <= 8'd0;
    else     hold_reg <= hold_next;
  end
`else
  assign timeout = 1'b0;
`endif

  // State register (grant/select/busy are registered outputs alongside the FSM state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      gnt_reg   <= '0;
      sel_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      gnt_reg   <= gnt_next;
      sel_reg   <= sel_next;
      busy_reg  <= busy_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: if (found) state_next = OWN;
      OWN: begin
        if (owner_done) begin
          state_next = GAP;
          ptr_next   = sel_reg + SEL_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    gnt_next  = gnt_reg;
    sel_next  = sel_reg;
    busy_next = busy_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          gnt_next      = '0;
          gnt_next[win] = 1'b1;
          sel_next      = win;
          busy_next     = 1'b1;
        end else begin
          busy_next = 1'b0;
        end
      end
      OWN: begin
        if (owner_done) begin
          gnt_next  = '0;
          busy_next = 1'b0;
        end
      end
      default: begin
        gnt_next  = '0;
        busy_next = 1'b0;
      end
    endcase
  end

  assign gnt  = gnt_reg;
  assign sel  = sel_reg;
  assign busy = busy_reg;

  // Heap-ordered mux tree: node k has children 2k+1 (sel bit 0) and 2k+2 (sel bit 1);
  // the root decodes the select MSB, leaves sit at NUM_REQ-1+i.
  logic [2*NUM_REQ-2:0] tree;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_leaf
    assign tree[NUM_REQ-1+gi] = data_in[gi];
  end

  for (genvar gi = 0; gi < SEL_W; gi++) begin : g_level
    for (genvar gj = 0; gj < (1 << gi); gj++) begin : g_node
      localparam int K = (1 << gi) - 1 + gj;
      mux_0 u_mux (
        .a (tree[2*K+1]),
        .b (tree[2*K+2]),
        .s (sel_reg[SEL_W-1-gi]),
        .y (tree[K])
      );
    end
  end

  and_0 u_gate (
    .a (busy_reg),
    .b (tree[0]),
    .y (out)
  );

endmodule

// File: tb/tb_mux_arbiter_0.sv
// Directed testbench for mux_arbiter_0 (NUM_REQ=4, HOLD_MAX=8); timeout checks follow MUX_ARB_TIMEOUT_EN.

module tb_mux_arbiter_0;
  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] data_in;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       out;

  int vectors;
  int miscompares;

  mux_arbiter_0 #(.NUM_REQ(4), .HOLD_MAX(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data_in (data_in),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; data_in = 4'b0000;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; data_in = 4'b1111;
    tick(); tick();
    vectors += 4;
    if (gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    if (sel !== 2'd0)    begin miscompares++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    if (busy !== 1'b0)   begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (out !== 1'b0)    begin miscompares++; $display("FAIL reset_out got=%b exp=0", out); end
    rst = 1'b0;
    tick();
    vectors += 3;
    if (gnt !== 4'b0001) begin miscompares++; $display("FAIL first_gnt got=%b exp=0001", gnt); end
    if (sel !== 2'd0)    begin miscompares++; $display("FAIL first_sel got=%0d exp=0", sel); end
    if (busy !== 1'b1)   begin miscompares++; $display("FAIL first_busy got=%b exp=1", busy); end
    $display("reset: gnt=%b sel=%0d busy=%b", gnt, sel, busy);
  endtask

  // Starts with owner 0 granted and req=1111; expects order 0,1,2,3,0.
  task automatic test_round_robin();
    logic [3:0] exp_next;
    for (int owner = 0; owner < 4; owner++) begin
      tick();
      vectors++;
      if (gnt !== (4'b0001 << owner)) begin
        miscompares++; $display("FAIL rr_hold owner=%0d got=%b exp=%b", owner, gnt, 4'b0001 << owner);
      end
      req[owner] = 1'b0;
      tick();
      vectors += 2;
      if (gnt !== 4'b0000) begin miscompares++; $display("FAIL rr_gap1 owner=%0d got=%b exp=0000", owner, gnt); end
      if (busy !== 1'b0)   begin miscompares++; $display("FAIL rr_busy owner=%0d got=%b exp=0", owner, busy); end
      req[owner] = 1'b1;
      tick();
      vectors++;
      if (gnt !== 4'b0000) begin miscompares++; $display("FAIL rr_gap2 owner=%0d got=%b exp=0000", owner, gnt); end
      tick();
      exp_next = 4'b0001 << ((owner + 1) % 4);
      vectors += 2;
      if (gnt !== exp_next) begin miscompares++; $display("FAIL rr_next owner=%0d got=%b exp=%b", owner, gnt, exp_next); end
      if (sel !== 2'((owner + 1) % 4)) begin
        miscompares++; $display("FAIL rr_sel owner=%0d got=%0d exp=%0d", owner, sel, (owner + 1) % 4);
      end
      $display("rr: released %0d, granted gnt=%b sel=%0d", owner, gnt, sel);
    end
  endtask

  task automatic test_data_path();
    do_reset();
    req = 4'b0100;
    tick();
    vectors += 2;
    if (gnt !== 4'b0100) begin miscompares++; $display("FAIL dp_gnt got=%b exp=0100", gnt); end
    if (sel !== 2'd2)    begin miscompares++; $display("FAIL dp_sel got=%0d exp=2", sel); end
    data_in = 4'b0100; #1;
    vectors++;
    if (out !== 1'b1) begin miscompares++; $display("FAIL dp_out_one got=%b exp=1", out); end
    data_in = 4'b1011; #1;
    vectors++;
    if (out !== 1'b0) begin miscompares++; $display("FAIL dp_out_zero got=%b exp=0", out); end
    req = 4'b0000;
    tick();
    data_in = 4'b1111; #1;
    vectors += 3;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL dp_rel_busy got=%b exp=0", busy); end
    if (sel !== 2'd2)  begin miscompares++; $display("FAIL dp_rel_sel got=%0d exp=2", sel); end
    if (out !== 1'b0)  begin miscompares++; $display("FAIL dp_rel_out got=%b exp=0", out); end
    $display("data_path: out gated after release, sel=%0d", sel);
  endtask

  // Continues from test_data_path: owner 2 just released, ptr=3, FSM in GAP.
  task automatic test_wrap_and_skip();
    req = 4'b0001;
    tick();
    vectors++;
    if (gnt !== 4'b0000) begin miscompares++; $display("FAIL wrap_idle got=%b exp=0000", gnt); end
    tick();
    vectors++;
    if (gnt !== 4'b0001) begin miscompares++; $display("FAIL wrap_gnt got=%b exp=0001", gnt); end
    req = 4'b0000;
    tick(); tick();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b1001;
    tick(); tick();
    vectors++;
    if (gnt !== 4'b1000) begin miscompares++; $display("FAIL ptr_prio got=%b exp=1000", gnt); end
    req = 4'b1111; tick();
    vectors++;
    if (gnt !== 4'b1000) begin miscompares++; $display("FAIL skip_a got=%b exp=1000", gnt); end
    req = 4'b1011; tick();
    vectors++;
    if (gnt !== 4'b1000) begin miscompares++; $display("FAIL skip_b got=%b exp=1000", gnt); end
    req = 4'b1000; tick();
    vectors++;
    if (gnt !== 4'b1000) begin miscompares++; $display("FAIL skip_c got=%b exp=1000", gnt); end
    $display("wrap_and_skip: owner 3 held gnt=%b", gnt);
  endtask

  // Continues with owner 3 active.
  task automatic test_reset_mid_grant();
    rst = 1'b1;
    tick();
    vectors += 3;
    if (gnt !== 4'b0000) begin miscompares++; $display("FAIL midrst_gnt got=%b exp=0000", gnt); end
    if (busy !== 1'b0)   begin miscompares++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    if (sel !== 2'd0)    begin miscompares++; $display("FAIL midrst_sel got=%0d exp=0", sel); end
    rst = 1'b0; req = 4'b1001;
    tick();
    vectors++;
    if (gnt !== 4'b0001) begin miscompares++; $display("FAIL midrst_regnt got=%b exp=0001", gnt); end
    $display("reset_mid_grant: gnt=%b", gnt);
  endtask

  task automatic test_drop_before_grant();
    do_reset();
    req = 4'b0001; tick();
    req = 4'b0011; tick();
    req = 4'b0001; tick();
    req = 4'b0000; tick();
    tick(); tick();
    vectors += 2;
    if (gnt !== 4'b0000) begin miscompares++; $display("FAIL drop_gnt got=%b exp=0000", gnt); end
    if (busy !== 1'b0)   begin miscompares++; $display("FAIL drop_busy got=%b exp=0", busy); end
    $display("drop_before_grant: gnt=%b busy=%b", gnt, busy);
  endtask

  task automatic test_hold();
    logic [3:0] exp_gnt;
    int         phase;
    do_reset();
    req = 4'b0011;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
`ifdef MUX_ARB_TIMEOUT_EN
      phase = cyc % 20;
      if (phase < 8)       exp_gnt = 4'b0001;
      else if (phase < 10) exp_gnt = 4'b0000;
      else if (phase < 18) exp_gnt = 4'b0010;
      else                 exp_gnt = 4'b0000;
`else
      phase   = cyc;
      exp_gnt = 4'b0001;
`endif
      vectors++;
      if (gnt !== exp_gnt) begin
        miscompares++; $display("FAIL hold cyc=%0d phase=%0d got=%b exp=%b", cyc, phase, gnt, exp_gnt);
      end
    end
    $display("hold: final gnt=%b", gnt);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; req = 4'b0000; data_in = 4'b0000;
    test_reset();
    test_round_robin();
    test_data_path();
    test_wrap_and_skip();
    test_reset_mid_grant();
    test_drop_before_grant();
    test_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
